// File: rtl/aes_pkg.sv
// Shared AES inverse-cipher definitions: inverse S-box, GF(2^8) helpers, round counts, FSM states.
package aes_pkg;

  localparam int NR_128 = 10;
  localparam int NR_192 = 12;
  localparam int NR_256 = 14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Entry 0x00 sits in the top byte; row n holds entries 16n..16n+15.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[2047 - 8*int'(b) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_add_round_key.sv
// AddRoundKey: bitwise XOR of a 128-bit state with a round key.
module aes_add_round_key (
  input  logic [127:0] i_state,
  input  logic [127:0] i_rk,
  output logic [127:0] o_state
);

  assign o_state = i_state ^ i_rk;

endmodule

// File: rtl/aes_inv_round.sv
// Combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then InvMixColumns
// unless this is the final round.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [127:0] i_state,
  input  logic [127:0] i_rk,
  input  logic         i_final,
  output logic [127:0] o_state
);

  logic [127:0] w_sub;
  logic [127:0] w_ark;
  logic [127:0] w_mix;

  // Byte index is 4*col + row; row r of the output takes column (c - r) mod 4 of the input.
  always_comb begin
    w_sub = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_sub[127-8*(4*c+r) -: 8] = inv_sbox(i_state[127-8*(4*((c+4-r)%4)+r) -: 8]);
      end
    end
  end

  aes_add_round_key u_ark (
    .i_state (w_sub),
    .i_rk    (i_rk),
    .o_state (w_ark)
  );

  always_comb begin
    w_mix = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        w_mix[127-8*(4*c+r) -: 8] =
            gmul(w_ark[127-8*(4*c+r)       -: 8], 8'h0e)
          ^ gmul(w_ark[127-8*(4*c+(r+1)%4) -: 8], 8'h0b)
          ^ gmul(w_ark[127-8*(4*c+(r+2)%4) -: 8], 8'h0d)
          ^ gmul(w_ark[127-8*(4*c+(r+3)%4) -: 8], 8'h09);
      end
    end
  end

  assign o_state = i_final ? w_ark : w_mix;

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher, one inverse round per clock, external round-key lookup.
// Optional abort input enabled by defining AES_INV_ABORT_EN.
//   state | meaning
//   IDLE  | ready for a ciphertext; rk_index = NR for the initial key addition
//   ROUND | one inverse round per edge, rk_index = round counter
//   DONE  | plaintext held on out_block until out_ready
module aes_inv_cipher_iter
  import aes_pkg::*;
#(
  parameter int NR = NR_128
) (
  input  logic         clk,
  input  logic         reset_n,
`ifdef AES_INV_ABORT_EN
  input  logic         abort,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_block,
  output logic [3:0]   rk_index,
  input  logic [127:0] rk_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic         busy
);

  localparam logic [3:0] NR_IDX = 4'(NR);

  state_e       r_state;
  state_e       w_state_nxt;
  logic [3:0]   r_cnt;
  logic [3:0]   w_cnt_nxt;
  logic [127:0] r_blk;
  logic [127:0] w_blk_nxt;
  logic [127:0] w_ark0;
  logic [127:0] w_round;

  aes_add_round_key u_ark0 (
    .i_state (in_block),
    .i_rk    (rk_data),
    .o_state (w_ark0)
  );

  aes_inv_round u_round (
    .i_state (r_blk),
    .i_rk    (rk_data),
    .i_final (r_cnt == 4'd0),
    .o_state (w_round)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_blk   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_blk   <= w_blk_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_blk_nxt   = r_blk;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    rk_index    = 4'd0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        rk_index = NR_IDX;
        if (in_valid) begin
          w_blk_nxt   = w_ark0;
          w_cnt_nxt   = NR_IDX - 4'd1;
          w_state_nxt = ROUND;
        end
      end
      ROUND: begin
        rk_index  = r_cnt;
        w_blk_nxt = w_round;
        if (r_cnt == 4'd0) w_state_nxt = DONE;
        else               w_cnt_nxt   = r_cnt - 4'd1;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
`ifdef AES_INV_ABORT_EN
    // Abort wins over both the final-round transition and the output handshake.
    if (abort && (r_state != IDLE)) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = 4'd0;
    end
`endif
  end

  assign out_block = r_blk;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for aes_inv_cipher_iter: FIPS-197 vectors plus random blocks against a forward-cipher model.
module tb_aes_inv_cipher_iter;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FIPS_PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] C3_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] in_block, rk_data, out_block;
  logic [3:0]   rk_index;
  logic         in_valid14, in_ready14, out_valid14, out_ready14, busy14;
  logic [127:0] in_block14, rk_data14, out_block14;
  logic [3:0]   rk_index14;
`ifdef AES_INV_ABORT_EN
  logic         abort;
  logic         abort14;
`endif

  logic [127:0] rk10 [0:15];
  logic [127:0] rk14 [0:15];
  logic [127:0] ks   [0:15];
  logic [7:0]   sb   [0:255];
  logic [7:0]   isb  [0:255];

  int checks = 0;
  int errors = 0;

  assign rk_data   = rk10[rk_index];
  assign rk_data14 = rk14[rk_index14];

  aes_inv_cipher_iter #(.NR(10)) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
`ifdef AES_INV_ABORT_EN
    .abort     (abort),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_block  (in_block),
    .rk_index  (rk_index),
    .rk_data   (rk_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block),
    .busy      (busy)
  );

  aes_inv_cipher_iter #(.NR(14)) u_dut14 (
    .clk       (clk),
    .reset_n   (reset_n),
`ifdef AES_INV_ABORT_EN
    .abort     (abort14),
`endif
    .in_valid  (in_valid14),
    .in_ready  (in_ready14),
    .in_block  (in_block14),
    .rk_index  (rk_index14),
    .rk_data   (rk_data14),
    .out_valid (out_valid14),
    .out_ready (out_ready14),
    .out_block (out_block14),
    .busy      (busy14)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, observed=running required=finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // GF(2^8) product reduced by x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    int p;
    p = 0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (int'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (32'h11b << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int k);
    logic [15:0] d;
    d = {b, b};
    return d[15-k -: 8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (x != 0 && gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      sb[x]  = s;
      isb[s] = 8'(x);
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  // Key schedule; key is left-aligned in 256 bits, Nk = nr - 6 words.
  task automatic expand(input logic [255:0] key, input int nr);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc;
    int nk;
    nk = nr - 6;
    rc = 8'h01;
    for (int i = 0; i < 16; i++) ks[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gm(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] pt, input int nr);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ ks[0][127-8*i -: 8];
    for (int rd = 1; rd <= nr; rd++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[4*(((i/4) + (i%4)) % 4) + i%4]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          s[4*c+r] = (rd == nr) ? t[4*c+r] :
                     gm(t[4*c+r], 8'h02) ^ gm(t[4*c+(r+1)%4], 8'h03) ^ t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4];
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ ks[rd][127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  function automatic logic [127:0] decrypt(input logic [127:0] ct, input int nr);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [127:0] o;
    for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8] ^ ks[nr][127-8*i -: 8];
    for (int rd = nr - 1; rd >= 0; rd--) begin
      for (int i = 0; i < 16; i++)
        t[i] = isb[s[4*(((i/4) - (i%4) + 4) % 4) + i%4]] ^ ks[rd][127-8*i -: 8];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          s[4*c+r] = (rd == 0) ? t[4*c+r] :
                     gm(t[4*c+r], 8'h0e) ^ gm(t[4*c+(r+1)%4], 8'h0b) ^
                     gm(t[4*c+(r+2)%4], 8'h0d) ^ gm(t[4*c+(r+3)%4], 8'h09);
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  task automatic send(input logic [127:0] blk);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_block = blk;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("accept_wait", 128'(n < 50), 128'(1));
    chk("rk_index_idle", 128'(rk_index), 128'(10));
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_block = {$urandom, $urandom, $urandom, $urandom};
    chk("busy_after_accept", 128'(busy), 128'(1));
    chk("in_ready_round", 128'(in_ready), 128'(0));
  endtask

  task automatic collect(input logic [127:0] exp, input int stall);
    int n;
    n = 0;
    out_ready = (stall == 0);
    while (out_valid !== 1'b1 && n < 40) begin
      chk("rk_index_round", 128'(rk_index), 128'(9 - n));
      @(posedge clk); #1; n++;
    end
    chk("latency", 128'(n), 128'(10));
    chk("out_block", out_block, exp);
    chk("busy_done", 128'(busy), 128'(1));
    chk("rk_index_done", 128'(rk_index), 128'(0));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk("stall_out_valid", 128'(out_valid), 128'(1));
      chk("stall_out_block", out_block, exp);
      chk("stall_in_ready", 128'(in_ready), 128'(0));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("out_valid_after_hs", 128'(out_valid), 128'(0));
    chk("busy_after_hs", 128'(busy), 128'(0));
    chk("in_ready_after_hs", 128'(in_ready), 128'(1));
  endtask

  initial begin
    int n;
    logic [127:0] pt, ct, pt2, ct2, exp0;

    reset_n = 1'b0;
    in_valid = 1'b0; in_block = '0; out_ready = 1'b1;
    in_valid14 = 1'b0; in_block14 = '0; out_ready14 = 1'b1;
`ifdef AES_INV_ABORT_EN
    abort = 1'b0; abort14 = 1'b0;
`endif
    build_sbox();
    expand({C1_KEY, 128'h0}, 10);
    rk10 = ks;
    expand(C3_KEY, 14);
    rk14 = ks;
    expand({C1_KEY, 128'h0}, 10);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_out_block", out_block, '0);
    chk("rst_rk_index", 128'(rk_index), 128'(10));
    reset_n = 1'b1;
    @(posedge clk); #1;

    // FIPS-197 C.1
    send(C1_CT);
    collect(FIPS_PT, 0);

    // Backpressure with a second block waiting on in_valid
    pt2 = {$urandom, $urandom, $urandom, $urandom};
    ct2 = encrypt(pt2, 10);
    send(C1_CT);
    in_valid = 1'b1;
    in_block = ct2;
    collect(FIPS_PT, 5);
    send(ct2);
    collect(pt2, 0);

    // Back-to-back, then all-zero key / ciphertext
    send(C1_CT);
    collect(FIPS_PT, 0);
    send(C1_CT);
    collect(FIPS_PT, 0);
    expand(256'h0, 10);
    rk10 = ks;
    exp0 = decrypt(128'h0, 10);
    send(128'h0);
    collect(exp0, 0);

    // Reset while the round counter is 5
    expand({C1_KEY, 128'h0}, 10);
    rk10 = ks;
    send(C1_CT);
    n = 0;
    while (rk_index !== 4'd5 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("reach_round5", 128'(n < 20), 128'(1));
    reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_in_ready", 128'(in_ready), 128'(1));
    chk("midrst_busy", 128'(busy), 128'(0));
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_no_stale", out_block, '0);
    chk("midrst_idle_valid", 128'(out_valid), 128'(0));
    send(C1_CT);
    collect(FIPS_PT, 0);

    // Random plaintexts under random keys, random stalls
    for (int k = 0; k < 6; k++) begin
      expand({{$urandom, $urandom, $urandom, $urandom}, 128'h0}, 10);
      rk10 = ks;
      pt = {$urandom, $urandom, $urandom, $urandom};
      ct = encrypt(pt, 10);
      send(ct);
      collect(pt, int'($urandom_range(0, 3)));
    end

    // NR = 14 instance, FIPS-197 C.3
    in_valid14 = 1'b1;
    in_block14 = C3_CT;
    chk("nr14_in_ready", 128'(in_ready14), 128'(1));
    chk("nr14_rk_index", 128'(rk_index14), 128'(14));
    @(posedge clk); #1;
    in_valid14 = 1'b0;
    n = 0;
    while (out_valid14 !== 1'b1 && n < 40) begin
      @(posedge clk); #1; n++;
    end
    chk("nr14_latency", 128'(n), 128'(14));
    chk("nr14_out_block", out_block14, FIPS_PT);
    @(posedge clk); #1;
    chk("nr14_after_hs", 128'(out_valid14), 128'(0));

`ifdef AES_INV_ABORT_EN
    expand({C1_KEY, 128'h0}, 10);
    rk10 = ks;
    abort = 1'b1;
    send(C1_CT);
    abort = 1'b0;
    n = 0;
    while (rk_index !== 4'd3 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("reach_round3", 128'(n < 20), 128'(1));
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_in_ready", 128'(in_ready), 128'(1));
    n = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid !== 1'b0) n++;
      @(posedge clk); #1;
    end
    chk("abort_no_out_valid", 128'(n), 128'(0));
    send(C1_CT);
    collect(FIPS_PT, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_inv_cipher_iter.md
Name: aes_inv_cipher_iter

Overview:
Iterative AES inverse cipher (decryption) datapath that performs one inverse round per clock. It takes a 128-bit ciphertext block through a valid/ready handshake and fetches round keys from an external key-schedule store through an index/data lookup. It returns the plaintext through a valid/ready handshake. This block is the decrypt-side counterpart of the encrypt round datapath, and it reuses the existing AddRoundKey XOR block for every key addition.

Parameters:
NR, 10, number of rounds; legal values 10, 12, 14 (AES-128/192/256); rk_index width fixed at 4 bits.

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
in_valid  input  1  ciphertext block offered
in_ready  output  1  block accepted when in_valid && in_ready
in_block  input  128  ciphertext; byte 0 = [127:120], column-major per FIPS-197
rk_index  output  4  round-key index requested; combinational from state
rk_data  input  128  round key for rk_index, valid in the same cycle (combinational lookup)
out_valid  output  1  plaintext available
out_ready  input  1  consumer accepts when out_valid && out_ready
out_block  output  128  plaintext, same byte ordering
busy  output  1  high in ROUND or DONE

Behaviour:
- States: IDLE, ROUND, DONE. Async reset_n low -> IDLE, round counter = 0, state register = 0, out_valid = 0, in_ready = 1, busy = 0, out_block = 0.
- IDLE: in_ready = 1, rk_index = NR. On accept: state <= in_block ^ rk_data (AddRoundKey with rk[NR]); counter <= NR-1; go to ROUND.
- ROUND: rk_index = counter.
  - If counter != 0: state <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), rk_data)); counter decrements.
  - If counter == 0: final round, with no InvMixColumns; go to DONE.
- DONE: out_valid = 1; out_block = state register, held stable until handshake. On out_ready: go to IDLE. in_ready = 0 in DONE, so there is no same-cycle reload.
- Latency: out_valid rises NR clock edges after the accepting edge. Throughput is one block per NR+2 cycles.
- in_valid while busy is ignored; in_block is sampled only at the accepting edge.
- rk_index in DONE = 0. rk_data is ignored outside IDLE-accept and ROUND.
- Reset asserted mid-ROUND or in DONE: immediate return to IDLE, the partial block is discarded, and out_valid drops asynchronously.
- GF(2^8) arithmetic uses the polynomial 0x11B. InvMixColumns coefficients are 0e, 0b, 0d, 09.

Optional Feature:
AES_INV_ABORT_EN
- Defined: adds input port abort (1 bit). abort high in ROUND or DONE -> next edge goes to IDLE, out_valid = 0, and no output handshake occurs. abort has priority over the final-round transition and over out_ready. abort in IDLE has no effect, and a same-cycle in_valid is still accepted.
- Undefined: no abort port; behaviour as above.

Decomposition:
- Package aes_pkg holds:
  - INV_SBOX constant table and inv_sbox function
  - xtime and gmul functions
  - NR_128/NR_192/NR_256 constants
  - state enum (IDLE, ROUND, DONE)
- Sub-module aes_inv_round: a combinational round function with inputs state, round key and final flag, and output next state. It instantiates AddRoundKey for the key XOR. The FSM, counter and handshakes stay in aes_inv_cipher_iter.

Test Plan:
- FIPS-197 C.1 vector:
  - Stimulus: bench key-schedule model for key 000102030405060708090a0b0c0d0e0f; send in_block 69c4e0d86a7b0430d8cdb78070b4c55a with out_ready = 1.
  - Response: out_block 00112233445566778899aabbccddeeff; out_valid first high exactly 10 edges after accept; rk_index sequence 10, 9, ..., 0.
- Backpressure:
  - Stimulus: same vector with out_ready held low 5 cycles after out_valid; in_valid held high with a second block during that time.
  - Response: out_block stable, in_ready = 0, second block accepted only after the output handshake plus return to IDLE.
- Back-to-back:
  - Stimulus: two C.1 ciphertexts, then an all-zero key/all-zero ciphertext block.
  - Response: outputs match the reference model in order; busy low only in IDLE.
- Reset mid-operation:
  - Stimulus: assert reset_n low during round counter = 5, then release and resend C.1.
  - Response: out_valid = 0 and in_ready = 1 immediately on reset; correct plaintext afterwards, no stale output.
- NR = 14 build:
  - Stimulus: C.3 key 000102...1f, ciphertext 8ea2b7ca516745bfeafc49904b496089.
  - Response: plaintext 00112233445566778899aabbccddeeff after 14 edges.
- Abort (AES_INV_ABORT_EN defined):
  - Stimulus: pulse abort at round counter = 3.
  - Response: next edge goes to IDLE, no out_valid pulse, and the following C.1 block decrypts correctly.
